// File: rtl/cpu_arb_pkg.sv
// Shared constants and types for the CPU command arbiter: command field layout,
// the default no-op command and the arbiter FSM state type.
package cpu_arb_pkg;

  localparam int CMD_W     = 7;
  localparam int SEL_A_MSB = 6;
  localparam int SEL_A_LSB = 5;
  localparam int SEL_B_MSB = 4;
  localparam int SEL_B_LSB = 3;
  localparam int OPC_MSB   = 2;
  localparam int OPC_LSB   = 0;

  localparam logic [CMD_W-1:0] NOP_CMD_DEFAULT = 7'h00;

  typedef enum logic {IDLE, ISSUED} arb_state_t;

  // Packs the three command fields into a sequencer command word.
  function automatic logic [CMD_W-1:0] make_cmd(input logic [1:0] sel_a,
                                                input logic [1:0] sel_b,
                                                input logic [2:0] opc);
    logic [CMD_W-1:0] c;
    c = '0;
    c[SEL_A_MSB:SEL_A_LSB] = sel_a;
    c[SEL_B_MSB:SEL_B_LSB] = sel_b;
    c[OPC_MSB:OPC_LSB]     = opc;
    return c;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid index strictly after ptr,
// searching upward modulo N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [IW:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int k = 1; k <= N; k++) begin
      // ptr + k never reaches 2N, so a single wrap subtraction is enough
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N)) cand = cand - (IW+1)'(N);
      if (!any && valid[cand[IW-1:0]]) begin
        any                = 1'b1;
        idx                = cand[IW-1:0];
        grant[cand[IW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_cmd_arbiter.sv
// Shares the CPU sequencer/ALU between NREQ requesters: one round-robin grant per
// FETCH slot, command/operand held while the op runs, result routed back to the owner.
module cpu_cmd_arbiter
  import cpu_arb_pkg::*;
#(
  parameter int                NREQ    = 4,
  parameter int                DW      = 8,
  parameter int                TIMEOUT = 15,
  parameter logic [CMD_W-1:0]  NOP_CMD = NOP_CMD_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*CMD_W-1:0] req_cmd,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       resp_valid,
  output logic                  resp_err,
  output logic [DW-1:0]         resp_data,
  output logic [CMD_W-1:0]      cmd_out,
  output logic [DW-1:0]         cpu_data_out,
  input  logic                  cpu_fetch,
  input  logic                  cpu_rdy,
  input  logic [DW-1:0]         cpu_result,
  output logic                  busy,
  output logic                  err_timeout,
  output logic [15:0]           op_count
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_t state, state_nxt;

  logic [NREQ-1:0]  win_grant;
  logic [IW-1:0]    win_idx;
  logic             win_any;
  logic [CMD_W-1:0] win_cmd;
  logic [DW-1:0]    win_data;
  logic             grant_en, done_ok, done_to;

  logic [IW-1:0]    ptr_q;
  logic [CW-1:0]    wait_cnt;
  logic [CMD_W-1:0] cmd_p0;
  logic [DW-1:0]    data_p0;
  logic [NREQ-1:0]  owner_p0;
  logic [NREQ-1:0]  vld_p1;
  logic             err_p1;
  logic [DW-1:0]    resp_data_p1;
  logic             err_sticky;
  logic [15:0]      op_cnt;

  rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .grant (win_grant),
    .idx   (win_idx),
    .any   (win_any)
  );

  always_comb begin
    win_cmd  = NOP_CMD;
    win_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_grant[i]) begin
        win_cmd  = req_cmd[i*CMD_W +: CMD_W];
        win_data = req_data[i*DW +: DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // rst_n gates the grant so req_ready/cpu_data_out read 0 while reset is held
  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state)
      IDLE: begin
        if (rst_n && cpu_fetch && win_any) begin
          grant_en  = 1'b1;
          state_nxt = ISSUED;
        end
      end
      ISSUED: begin
        if (cpu_rdy) begin
          done_ok   = 1'b1;
          state_nxt = IDLE;
        end else if (wait_cnt == CW'(TIMEOUT)) begin
          done_to   = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Grant stage (_p0) and response stage (_p1)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q        <= IW'(NREQ - 1);
      wait_cnt     <= '0;
      cmd_p0       <= NOP_CMD;
      data_p0      <= '0;
      owner_p0     <= '0;
      vld_p1       <= '0;
      err_p1       <= 1'b0;
      resp_data_p1 <= '0;
      err_sticky   <= 1'b0;
      op_cnt       <= '0;
    end else begin
      vld_p1 <= '0;
      err_p1 <= 1'b0;
      if (grant_en) begin
        cmd_p0   <= win_cmd;
        data_p0  <= win_data;
        owner_p0 <= win_grant;
        ptr_q    <= win_idx;
        wait_cnt <= CW'(1);
      end else if (state == IDLE && cpu_fetch) begin
        cmd_p0 <= NOP_CMD;
      end
      if (state == ISSUED && !(done_ok || done_to)) wait_cnt <= wait_cnt + CW'(1);
      if (done_ok) begin
        vld_p1       <= owner_p0;
        resp_data_p1 <= cpu_result;
        op_cnt       <= op_cnt + 16'd1;
      end else if (done_to) begin
        vld_p1       <= owner_p0;
        err_p1       <= 1'b1;
        resp_data_p1 <= '0;
        err_sticky   <= 1'b1;
        op_cnt       <= op_cnt + 16'd1;
      end
    end
  end

  assign req_ready    = grant_en ? win_grant : '0;
  assign cpu_data_out = grant_en ? win_data : data_p0;
  assign cmd_out      = cmd_p0;
  assign resp_valid   = vld_p1;
  assign resp_err     = err_p1;
  assign resp_data    = resp_data_p1;
  assign busy         = (state == ISSUED);
  assign err_timeout  = err_sticky;
  assign op_count     = op_cnt;

endmodule

// File: tb/tb_cpu_cmd_arbiter.sv
// Directed bench for cpu_cmd_arbiter: a sequencer-like driver runs 4-cycle
// instruction slots and each scenario task compares against hand-computed values.
module tb_cpu_cmd_arbiter;
  import cpu_arb_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [27:0] req_cmd;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic [3:0]  resp_valid;
  logic        resp_err;
  logic [7:0]  resp_data;
  logic [6:0]  cmd_out;
  logic [7:0]  cpu_data_out;
  logic        cpu_fetch;
  logic        cpu_rdy;
  logic [7:0]  cpu_result;
  logic        busy;
  logic        err_timeout;
  logic [15:0] op_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] s_rdy;
  logic [7:0] s_dout;
  logic [6:0] s_cmd1, s_cmd2;
  logic       s_busy1;
  logic [3:0] s_resp;
  logic [7:0] s_rdata;
  logic       s_rerr;

  logic [6:0] cmd_tab [4];
  logic [7:0] data_tab [4];

  always #5 clk = ~clk;

  cpu_cmd_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_data    (resp_data),
    .cmd_out      (cmd_out),
    .cpu_data_out (cpu_data_out),
    .cpu_fetch    (cpu_fetch),
    .cpu_rdy      (cpu_rdy),
    .cpu_result   (cpu_result),
    .busy         (busy),
    .err_timeout  (err_timeout),
    .op_count     (op_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tables();
    cmd_tab[0] = make_cmd(2'b01, 2'b10, 3'b011);
    cmd_tab[1] = make_cmd(2'b10, 2'b01, 3'b101);
    cmd_tab[2] = make_cmd(2'b11, 2'b00, 3'b110);
    cmd_tab[3] = make_cmd(2'b00, 2'b11, 3'b001);
    data_tab[0] = 8'h5A; data_tab[1] = 8'hB1; data_tab[2] = 8'hC2; data_tab[3] = 8'hD3;
    for (int i = 0; i < 4; i++) begin
      req_cmd[i*7 +: 7]  = cmd_tab[i];
      req_data[i*8 +: 8] = data_tab[i];
    end
  endtask

  task automatic pulse_reset();
    cpu_fetch = 1'b0; cpu_rdy = 1'b0; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // One normal sequencer slot: FETCH, LOAD, EXECUTE(rdy), then the response cycle,
  // which is also where the next slot's FETCH starts.
  task automatic run_slot(input logic [7:0] res, input logic drop,
                          output logic [3:0] rdy_o, output logic [7:0] dout_o,
                          output logic [6:0] cmd1_o, output logic [6:0] cmd2_o,
                          output logic busy1_o, output logic [3:0] resp_o,
                          output logic [7:0] rdata_o, output logic rerr_o);
    cpu_fetch = 1'b1; cpu_rdy = 1'b0;
    #1;
    rdy_o = req_ready; dout_o = cpu_data_out;
    tick();
    cpu_fetch = 1'b0;
    if (drop) req_valid = req_valid & ~rdy_o;
    cmd1_o = cmd_out; busy1_o = busy;
    tick();
    cmd2_o = cmd_out; cpu_rdy = 1'b1; cpu_result = res;
    tick();
    cpu_rdy = 1'b0;
    resp_o = resp_valid; rdata_o = resp_data; rerr_o = resp_err;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cpu_fetch = 1'b1; cpu_rdy = 1'b0; cpu_result = 8'h00;
    req_valid = 4'b1111;
    load_tables();
    tick(); tick();
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_checks++; if (cmd_out !== 7'h00) begin n_fail++; $display("FAIL reset_cmd got=%h exp=00", cmd_out); end
    n_checks++; if (cpu_data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", cpu_data_out); end
    n_checks++; if ({resp_valid, resp_err, resp_data} !== 13'h0) begin n_fail++; $display("FAIL reset_resp got=%b/%b/%h exp=0", resp_valid, resp_err, resp_data); end
    n_checks++; if ({busy, err_timeout, op_count} !== 18'h0) begin n_fail++; $display("FAIL reset_status got=%b/%b/%h exp=0", busy, err_timeout, op_count); end
    cpu_fetch = 1'b0; req_valid = 4'b0000;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    req_valid = 4'b0001;
    run_slot(8'hA5, 1'b1, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", s_rdy); end
    n_checks++; if (s_dout !== 8'h5A) begin n_fail++; $display("FAIL single_operand got=%h exp=5a", s_dout); end
    n_checks++; if (s_cmd1 !== 7'b0110011 || s_cmd2 !== 7'b0110011) begin n_fail++; $display("FAIL single_cmd got=%h,%h exp=33", s_cmd1, s_cmd2); end
    n_checks++; if (s_busy1 !== 1'b1) begin n_fail++; $display("FAIL single_busy got=%b exp=1", s_busy1); end
    n_checks++; if (s_resp !== 4'b0001 || s_rdata !== 8'hA5 || s_rerr !== 1'b0) begin n_fail++; $display("FAIL single_resp got=%b/%h/%b exp=0001/a5/0", s_resp, s_rdata, s_rerr); end
    n_checks++; if (op_count !== 16'd1 || busy !== 1'b0) begin n_fail++; $display("FAIL single_count got=%0d busy=%b exp=1 busy=0", op_count, busy); end
  endtask

  task automatic test_round_robin();
    int exp_w;
    pulse_reset();
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      exp_w = k % 4;
      run_slot(8'h10 + 8'(k), 1'b0, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
      n_checks++;
      if (s_rdy !== 4'(1 << exp_w) || s_cmd1 !== cmd_tab[exp_w] || s_resp !== 4'(1 << exp_w) || s_rdata !== 8'h10 + 8'(k))
        begin n_fail++; $display("FAIL rr_all slot%0d got=%b/%h/%b/%h exp=%b/%h/%b/%h", k, s_rdy, s_cmd1, s_resp, s_rdata, 4'(1 << exp_w), cmd_tab[exp_w], 4'(1 << exp_w), 8'h10 + 8'(k)); end
    end
    req_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      exp_w = (k % 2 == 0) ? 1 : 3;
      run_slot(8'h20 + 8'(k), 1'b0, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
      n_checks++;
      if (s_rdy !== 4'(1 << exp_w) || s_dout !== data_tab[exp_w] || s_resp !== 4'(1 << exp_w))
        begin n_fail++; $display("FAIL rr_odd slot%0d got=%b/%h/%b exp=%b/%h/%b", k, s_rdy, s_dout, s_resp, 4'(1 << exp_w), data_tab[exp_w], 4'(1 << exp_w)); end
    end
    n_checks++; if (op_count !== 16'd12) begin n_fail++; $display("FAIL rr_count got=%0d exp=12", op_count); end
  endtask

  task automatic test_idle_slot();
    req_valid = 4'b0000;
    run_slot(8'h99, 1'b0, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0000 || s_cmd1 !== 7'h00 || s_busy1 !== 1'b0) begin n_fail++; $display("FAIL idle_slot got=%b/%h/%b exp=0000/00/0", s_rdy, s_cmd1, s_busy1); end
    n_checks++; if (s_resp !== 4'b0000 || op_count !== 16'd12) begin n_fail++; $display("FAIL idle_resp got=%b/%0d exp=0000/12", s_resp, op_count); end
    cpu_fetch = 1'b1;
    tick();
    cpu_fetch = 1'b0; req_valid = 4'b0001;
    #1;
    n_checks++; if (req_ready !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL late_req_early got=%b/%b exp=0000/0", req_ready, busy); end
    tick(); tick();
    run_slot(8'h42, 1'b1, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0001 || s_resp !== 4'b0001 || s_rdata !== 8'h42) begin n_fail++; $display("FAIL late_req_grant got=%b/%b/%h exp=0001/0001/42", s_rdy, s_resp, s_rdata); end
  endtask

  task automatic test_timeout();
    req_valid = 4'b0100;
    cpu_fetch = 1'b1; cpu_rdy = 1'b0;
    #1;
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL to_ready got=%b exp=0100", req_ready); end
    tick();
    cpu_fetch = 1'b0; req_valid = 4'b0000;
    for (int i = 0; i < 15; i++) begin
      n_checks++; if (busy !== 1'b1 || resp_valid !== 4'b0000) begin n_fail++; $display("FAIL to_wait cyc%0d got=%b/%b exp=1/0000", i, busy, resp_valid); end
      tick();
    end
    n_checks++; if (resp_valid !== 4'b0100 || resp_err !== 1'b1 || resp_data !== 8'h00) begin n_fail++; $display("FAIL to_resp got=%b/%b/%h exp=0100/1/00", resp_valid, resp_err, resp_data); end
    n_checks++; if (err_timeout !== 1'b1 || busy !== 1'b0 || op_count !== 16'd14) begin n_fail++; $display("FAIL to_status got=%b/%b/%0d exp=1/0/14", err_timeout, busy, op_count); end
    req_valid = 4'b0010;
    run_slot(8'h77, 1'b1, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0010 || s_resp !== 4'b0010 || s_rerr !== 1'b0 || s_rdata !== 8'h77) begin n_fail++; $display("FAIL to_after got=%b/%b/%b/%h exp=0010/0010/0/77", s_rdy, s_resp, s_rerr, s_rdata); end
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL to_sticky got=%b exp=1", err_timeout); end
  endtask

  task automatic test_fetch_in_issued();
    req_valid = 4'b0011;
    cpu_fetch = 1'b1;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL fi_grant got=%b exp=0001", req_ready); end
    tick();
    req_valid = 4'b0010; cpu_fetch = 1'b1; cpu_rdy = 1'b1; cpu_result = 8'h3C;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL fi_no_regrant got=%b exp=0000", req_ready); end
    tick();
    cpu_fetch = 1'b0; cpu_rdy = 1'b0;
    n_checks++; if (resp_valid !== 4'b0001 || resp_data !== 8'h3C || busy !== 1'b0) begin n_fail++; $display("FAIL fi_done got=%b/%h/%b exp=0001/3c/0", resp_valid, resp_data, busy); end
    run_slot(8'h55, 1'b1, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0010 || s_resp !== 4'b0010 || op_count !== 16'd17) begin n_fail++; $display("FAIL fi_next got=%b/%b/%0d exp=0010/0010/17", s_rdy, s_resp, op_count); end
  endtask

  task automatic test_reset_mid_op();
    req_valid = 4'b0100;
    cpu_fetch = 1'b1;
    tick();
    cpu_fetch = 1'b0; req_valid = 4'b0000;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0 || cmd_out !== 7'h00 || cpu_data_out !== 8'h00 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_out got=%b/%h/%h/%b exp=0/00/00/0000", busy, cmd_out, cpu_data_out, req_ready); end
    n_checks++; if (op_count !== 16'd0 || err_timeout !== 1'b0 || resp_valid !== 4'b0000) begin n_fail++; $display("FAIL rst_mid_status got=%0d/%b/%b exp=0/0/0000", op_count, err_timeout, resp_valid); end
    cpu_rdy = 1'b1; cpu_result = 8'hEE;
    tick(); tick();
    cpu_rdy = 1'b0; rst_n = 1'b1;
    tick();
    n_checks++; if (resp_valid !== 4'b0000 || op_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_lost got=%b/%0d exp=0000/0", resp_valid, op_count); end
    req_valid = 4'b1111;
    run_slot(8'h61, 1'b0, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (s_rdy !== 4'b0001 || s_resp !== 4'b0001 || op_count !== 16'd1) begin n_fail++; $display("FAIL rst_mid_first got=%b/%b/%0d exp=0001/0001/1", s_rdy, s_resp, op_count); end
    req_valid = 4'b0000;
  endtask

  task automatic test_wrap_and_stray();
    force dut.op_cnt = 16'hFFFF;
    #1;
    release dut.op_cnt;
    #1;
    n_checks++; if (op_count !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_preload got=%h exp=ffff", op_count); end
    req_valid = 4'b0001;
    run_slot(8'h0F, 1'b1, s_rdy, s_dout, s_cmd1, s_cmd2, s_busy1, s_resp, s_rdata, s_rerr);
    n_checks++; if (op_count !== 16'h0000 || s_resp !== 4'b0001) begin n_fail++; $display("FAIL wrap got=%h/%b exp=0000/0001", op_count, s_resp); end
    cpu_rdy = 1'b1; cpu_result = 8'hC3;
    tick();
    cpu_rdy = 1'b0;
    tick();
    n_checks++; if (resp_valid !== 4'b0000 || op_count !== 16'h0000 || busy !== 1'b0) begin n_fail++; $display("FAIL stray_rdy got=%b/%h/%b exp=0000/0000/0", resp_valid, op_count, busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_idle_slot();
    test_timeout();
    test_fetch_in_issued();
    test_reset_mid_op();
    test_wrap_and_stray();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
